// File: rtl/mem256x16_burst_ctrl.sv
// Burst initiator for a 256x16 single-port RAM with asynchronous read.
// Optional readback check enabled by defining MEM_BURST_VERIFY_EN.
module mem256x16_burst_ctrl #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          verify_err,
  output logic          mem_WEn,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_qout
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_FLUSH,
    RD_CAP,
    RD_HOLD,
`ifdef MEM_BURST_VERIFY_EN
    VERIFY,
`endif
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] count;

`ifdef MEM_BURST_VERIFY_EN
  logic [AW-1:0] start_addr;
  logic [AW-1:0] burst_len;
  logic [DW-1:0] wr_xor;
  logic [DW-1:0] rd_xor;
`else
  assign verify_err = 1'b0;
`endif

  // Handshake and status outputs are pure decodes of the state register.
  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WR);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // clears every register here (the RAM itself lives outside this block).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      count    <= '0;
      mem_WEn  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
`ifdef MEM_BURST_VERIFY_EN
      start_addr <= '0;
      burst_len  <= '0;
      wr_xor     <= '0;
      rd_xor     <= '0;
      verify_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mem_addr <= cmd_addr;
            ptr      <= cmd_addr;
            count    <= cmd_len;
            state    <= cmd_we ? WR : RD_CAP;
`ifdef MEM_BURST_VERIFY_EN
            start_addr <= cmd_addr;
            burst_len  <= cmd_len;
            wr_xor     <= '0;
            rd_xor     <= '0;
            verify_err <= 1'b0;
`endif
          end
        end
        WR: begin
          if (wr_valid) begin
            mem_data <= wr_data;
            mem_WEn  <= 1'b1;
            mem_addr <= ptr;
            ptr      <= ptr + 1'b1;
`ifdef MEM_BURST_VERIFY_EN
            wr_xor   <= wr_xor ^ wr_data;
`endif
            if (count == '0) state <= WR_FLUSH;
            else             count <= count - 1'b1;
          end else begin
            mem_WEn <= 1'b0;
          end
        end
        // The last beat commits at this edge; the RAM samples the old address.
        WR_FLUSH: begin
          mem_WEn <= 1'b0;
`ifdef MEM_BURST_VERIFY_EN
          mem_addr <= start_addr;
          count    <= burst_len;
          state    <= VERIFY;
`else
          state    <= DONE;
`endif
        end
        RD_CAP: begin
          rd_data  <= mem_qout;
          rd_valid <= 1'b1;
          state    <= RD_HOLD;
        end
        RD_HOLD: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            mem_addr <= mem_addr + 1'b1;
            if (count == '0) begin
              state <= DONE;
            end else begin
              count <= count - 1'b1;
              state <= RD_CAP;
            end
          end
        end
`ifdef MEM_BURST_VERIFY_EN
        // Reread one address per cycle and fold it into the readback checksum.
        VERIFY: begin
          rd_xor   <= rd_xor ^ mem_qout;
          mem_addr <= mem_addr + 1'b1;
          if (count == '0) begin
            if ((rd_xor ^ mem_qout) != wr_xor) verify_err <= 1'b1;
            state <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem256x16_burst_ctrl.sv
// Scoreboard bench for mem256x16_burst_ctrl: a behavioural RAM, a word-array
// reference model, and a monitor that checks every read beat against a queue.
module tb_mem256x16_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_addr = '0, cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_data;
  logic        busy, done, verify_err, mem_WEn;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data, mem_qout;

  always #5 clk = ~clk;

  mem256x16_burst_ctrl #(.DW(16), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .verify_err(verify_err),
    .mem_WEn(mem_WEn), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_qout(mem_qout)
  );

  function automatic logic [15:0] init_word(int i);
    return 16'((i * 40503 + 7) & 16'hFFFF);
  endfunction

  // Behavioural RAM: synchronous write, asynchronous read.
  logic [15:0] ram [256];
  bit          ram_loaded = 1'b0;
`ifdef MEM_BURST_VERIFY_EN
  bit          corrupt_arm = 1'b0;
`endif
  assign mem_qout = ram[mem_addr];

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (mem_WEn) begin
      ram[mem_addr] <= mem_data;
`ifdef MEM_BURST_VERIFY_EN
      if (corrupt_arm && mem_addr == 8'd7) ram[5] <= ram[5] ^ 16'h0100;
`endif
    end
  end

  int          vectors = 0, miscompares = 0;
  logic [15:0] ref_mem [256];
  logic [15:0] wbuf [256];
  logic [15:0] exp_q [$];
  int          done_cnt = 0, wen_cnt = 0, exp_dones = 0;
  int          rd_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer: 0 always ready, 1 random, 2 stall five cycles per beat.
  int stall = 0;
  always @(posedge clk) begin
    #1;
    case (rd_mode)
      0: rd_ready = 1'b1;
      1: rd_ready = 1'($urandom_range(0, 1));
      default: begin
        if (rd_valid && stall < 5) begin
          rd_ready = 1'b0;
          stall++;
        end else begin
          rd_ready = rd_valid;
          stall = 0;
        end
      end
    endcase
  end

  // Monitor: counts pulses and write cycles, checks read beats and hold behaviour.
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data;
  logic [7:0]  prev_addr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (mem_WEn) begin
        wen_cnt++;
        check("wen_scope", {busy, done, rd_valid}, 3'b100);
      end
      if (rd_valid && prev_hold) begin
        check("rd_stable", rd_data, prev_data);
        check("addr_hold", mem_addr, prev_addr);
      end
      if (rd_valid && rd_ready) begin
        check("rd_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rd_data", rd_data, exp_q.pop_front());
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
      prev_addr = mem_addr;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic issue(input bit we, input logic [7:0] a, input logic [7:0] len);
    int t = 0;
    while (!cmd_ready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (!done && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_pulse_len", done, 0);
    check("idle_after_done", busy, 0);
    check("done_count", done_cnt, exp_dones);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [7:0] a, input int n, input bit gaps, input bit exp_verr);
    int w0 = wen_cnt;
    issue(1'b1, a, 8'(n - 1));
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      @(posedge clk); #1;
      wr_valid = 1'b0;
      ref_mem[8'(a + 8'(i))] = wbuf[i];
    end
    exp_dones++;
    wait_done(80);
    check("wen_cycles", wen_cnt - w0, n);
    check("verify_err", verify_err, exp_verr);
  endtask

  task automatic do_read(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[8'(a + 8'(i))]);
    issue(1'b0, a, 8'(n - 1));
    exp_dones++;
    wait_done(n * 10 + 20);
    check("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_outputs", {busy, done, wr_ready, rd_valid, mem_WEn, verify_err}, 6'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_regs", {mem_addr, mem_data, rd_data}, 40'h0);

    // Directed four-beat write then readback.
    wbuf[0] = 16'h0000; wbuf[1] = 16'h0001; wbuf[2] = 16'h0010; wbuf[3] = 16'h0006;
    do_write(8'h00, 4, 1'b0, 1'b0);
    do_read(8'h00, 4);

    // Address wrap across FF -> 00.
    for (int i = 0; i < 4; i++) wbuf[i] = 16'hA1 + 16'(i);
    do_write(8'hFE, 4, 1'b1, 1'b0);
    rd_mode = 1;
    do_read(8'hFE, 4);

    // Stalled consumer: data and address must hold until handshake.
    rd_mode = 2;
    do_read(8'h10, 3);
    rd_mode = 0;

    // Command pulsed while busy must be ignored.
    fork
      do_read(8'h20, 4);
      begin
        repeat (4) begin @(posedge clk); #1; end
        check("busy_cmd_ready", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h80; cmd_len = 8'h03;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("busy_no_wr", wr_ready, 0);
      end
    join

    // Reset in the middle of an eight-beat write: beats 0 and 1 land, beat 2 is lost.
    for (int i = 0; i < 8; i++) wbuf[i] = 16'hC000 + 16'(i);
    issue(1'b1, 8'h00, 8'd7);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("abort_wen", mem_WEn, 0);
    check("abort_busy", busy, 0);
    ref_mem[0] = wbuf[0];
    ref_mem[1] = wbuf[1];
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_done", done_cnt, exp_dones);
    do_read(8'h00, 8);

    // Randomised bursts against the reference array.
    for (int k = 0; k < 25; k++) begin
      logic [7:0] a;
      int         n;
      a = 8'($urandom);
      n = $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
        do_write(a, n, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        rd_mode = $urandom_range(0, 1);
        do_read(a, n);
      end
    end

    // Full 256-word burst touching every address once.
    rd_mode = 0;
    for (int i = 0; i < 256; i++) wbuf[i] = 16'($urandom);
    begin
      logic [7:0] a;
      a = 8'($urandom);
      do_write(a, 256, 1'b0, 1'b0);
      do_read(a, 256);
    end

`ifdef MEM_BURST_VERIFY_EN
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h5A00 + 16'(i);
    corrupt_arm = 1'b1;
    do_write(8'h00, 8, 1'b0, 1'b1);
    corrupt_arm = 1'b0;
    ref_mem[5] = ref_mem[5] ^ 16'h0100;
    issue(1'b0, 8'h00, 8'd0);
    check("verify_err_clear", verify_err, 0);
    exp_q.push_back(ref_mem[0]);
    exp_dones++;
    wait_done(30);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
